// File: rtl/cl_mem_stage.sv
// Memory-access stage: runs one valid/ready data-memory transaction per load/store and
// produces the load writeback. Define CL_MEM_MISALIGN_CHK_EN to trap misaligned word ops.
module cl_mem_stage #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic                 is_load_i,
    input  logic                 is_store_i,
    input  logic                 is_byte_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [DATA_W-1:0]    store_data_i,
    input  logic [RF_ADDR_W-1:0] rd_addr_i,
    output logic                 stall_o,
    output logic                 result_valid_o,
    output logic                 rf_wen_o,
    output logic [RF_ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0]    rf_wdata_o,
    output logic                 dmem_req_valid_o,
    input  logic                 dmem_req_ready_i,
    output logic                 dmem_req_write_o,
    output logic [ADDR_W-1:0]    dmem_req_addr_o,
    output logic [DATA_W-1:0]    dmem_req_wdata_o,
    output logic [3:0]           dmem_req_mask_o,
    input  logic                 dmem_resp_valid_i,
    input  logic [DATA_W-1:0]    dmem_resp_data_i,
    output logic                 misalign_o
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e                 state;
    logic                   lat_load;
    logic                   lat_byte;
    logic [1:0]             lat_lane;
    logic [RF_ADDR_W-1:0]   lat_rd;
    logic                   mem_op;
    logic [DATA_W-1:0]      load_value;

    assign mem_op = valid_i & (is_load_i | is_store_i);

    // Inputs are only sampled in IDLE, so stall must be combinational there.
    assign stall_o = ~reset & (((state == StIdle) & mem_op) | (state == StReq) |
                               (state == StResp));

    always_comb begin
        load_value = dmem_resp_data_i;
        if (lat_byte) begin
            load_value = {{(DATA_W-8){1'b0}}, dmem_resp_data_i[{lat_lane, 3'b000} +: 8]};
        end
    end

`ifdef CL_MEM_MISALIGN_CHK_EN
    logic word_misalign;
    assign word_misalign = ~is_byte_i & (addr_i[1:0] != 2'b00);
`else
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= StIdle;
            lat_load         <= 1'b0;
            lat_byte         <= 1'b0;
            lat_lane         <= 2'b00;
            lat_rd           <= '0;
            result_valid_o   <= 1'b0;
            rf_wen_o         <= 1'b0;
            rf_waddr_o       <= '0;
            rf_wdata_o       <= '0;
            dmem_req_valid_o <= 1'b0;
            dmem_req_write_o <= 1'b0;
            dmem_req_addr_o  <= '0;
            dmem_req_wdata_o <= '0;
            dmem_req_mask_o  <= 4'h0;
`ifdef CL_MEM_MISALIGN_CHK_EN
            misalign_o       <= 1'b0;
`endif
        end else begin
            // Writeback outputs are a single-cycle DONE pulse.
            result_valid_o <= 1'b0;
            rf_wen_o       <= 1'b0;
            rf_waddr_o     <= '0;
            rf_wdata_o     <= '0;
`ifdef CL_MEM_MISALIGN_CHK_EN
            misalign_o     <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
`ifdef CL_MEM_MISALIGN_CHK_EN
                    if (mem_op && word_misalign) begin
                        state          <= StDone;
                        lat_load       <= 1'b0;
                        result_valid_o <= 1'b1;
                        rf_waddr_o     <= rd_addr_i;
                        misalign_o     <= 1'b1;
                    end else
`endif
                    if (mem_op) begin
                        state            <= StReq;
                        lat_load         <= is_load_i;
                        lat_byte         <= is_byte_i;
                        lat_lane         <= addr_i[1:0];
                        lat_rd           <= rd_addr_i;
                        dmem_req_valid_o <= 1'b1;
                        dmem_req_write_o <= is_store_i;
                        dmem_req_addr_o  <= addr_i;
                        dmem_req_wdata_o <= '0;
                        dmem_req_mask_o  <= 4'h0;
                        if (is_store_i) begin
                            if (is_byte_i) begin
                                dmem_req_wdata_o <= {(DATA_W/8){store_data_i[7:0]}};
                                dmem_req_mask_o  <= 4'b0001 << addr_i[1:0];
                            end else begin
                                dmem_req_wdata_o <= store_data_i;
                                dmem_req_mask_o  <= 4'hF;
                            end
                        end
                    end
                end
                StReq: begin
                    if (dmem_req_ready_i) begin
                        dmem_req_valid_o <= 1'b0;
                        dmem_req_write_o <= 1'b0;
                        dmem_req_addr_o  <= '0;
                        dmem_req_wdata_o <= '0;
                        dmem_req_mask_o  <= 4'h0;
                        if (lat_load) begin
                            state <= StResp;
                        end else begin
                            state          <= StDone;
                            result_valid_o <= 1'b1;
                            rf_waddr_o     <= lat_rd;
                        end
                    end
                end
                StResp: begin
                    if (dmem_resp_valid_i) begin
                        state          <= StDone;
                        result_valid_o <= 1'b1;
                        rf_wen_o       <= 1'b1;
                        rf_waddr_o     <= lat_rd;
                        rf_wdata_o     <= load_value;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cl_mem_stage.sv
// Directed bench for cl_mem_stage: memory model, writeback scoreboard and immediate assertions.
// Define CL_MEM_MISALIGN_CHK_EN for both bench and design to cover the misalign trap.
module tb_cl_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, is_load_i, is_store_i, is_byte_i;
    logic [31:0] addr_i, store_data_i;
    logic [4:0]  rd_addr_i;
    logic        stall_o, result_valid_o, rf_wen_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        dmem_req_valid_o, dmem_req_ready_i, dmem_req_write_o;
    logic [31:0] dmem_req_addr_o, dmem_req_wdata_o;
    logic [3:0]  dmem_req_mask_o;
    logic        dmem_resp_valid_i;
    logic [31:0] dmem_resp_data_i;
    logic        misalign_o;

    always #5 clk = ~clk;

    cl_mem_stage #(.ADDR_W(32), .DATA_W(32), .RF_ADDR_W(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .valid_i          (valid_i),
        .is_load_i        (is_load_i),
        .is_store_i       (is_store_i),
        .is_byte_i        (is_byte_i),
        .addr_i           (addr_i),
        .store_data_i     (store_data_i),
        .rd_addr_i        (rd_addr_i),
        .stall_o          (stall_o),
        .result_valid_o   (result_valid_o),
        .rf_wen_o         (rf_wen_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_req_write_o (dmem_req_write_o),
        .dmem_req_addr_o  (dmem_req_addr_o),
        .dmem_req_wdata_o (dmem_req_wdata_o),
        .dmem_req_mask_o  (dmem_req_mask_o),
        .dmem_resp_valid_i(dmem_resp_valid_i),
        .dmem_resp_data_i (dmem_resp_data_i),
        .misalign_o       (misalign_o)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        chk_data;
        logic        mis;
    } exp_t;
    exp_t sb[$];

    // Memory model state
    logic [31:0] mem [logic [29:0]];
    int          ready_delay = 0;
    bit          resp_block  = 0;
    bit          stray_resp  = 0;
    int          n_req       = 0;
    int          stable_err  = 0;
    logic [31:0] last_addr   = '0;
    logic [31:0] last_wdata  = '0;
    logic [3:0]  last_mask   = '0;
    logic        last_write  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
    endfunction

    initial begin : mem_model
        int          wait_cnt;
        bit          vld_prev;
        bit          resp_pend;
        logic [31:0] a0, w0, w;
        logic [3:0]  m0;
        logic        wr0;
        wait_cnt = 0; vld_prev = 0; resp_pend = 0;
        a0 = '0; w0 = '0; m0 = '0; wr0 = 1'b0; w = '0;
        dmem_req_ready_i  = 1'b0;
        dmem_resp_valid_i = 1'b0;
        dmem_resp_data_i  = '0;
        forever begin
            @(negedge clk);
            if (dmem_req_ready_i && vld_prev) begin
                n_req++;
                if (last_write) begin
                    w = rd_mem(last_addr);
                    for (int i = 0; i < 4; i++)
                        if (last_mask[i]) w[8*i +: 8] = last_wdata[8*i +: 8];
                    mem[last_addr[31:2]] = w;
                end else if (!resp_block) begin
                    resp_pend = 1;
                end
            end
            dmem_resp_valid_i = resp_pend | stray_resp;
            dmem_resp_data_i  = resp_pend ? rd_mem(last_addr) : 32'hDEAD_BEEF;
            resp_pend = 0;
            if (dmem_req_valid_o) begin
                if (!vld_prev) begin
                    a0 = dmem_req_addr_o; w0 = dmem_req_wdata_o;
                    m0 = dmem_req_mask_o; wr0 = dmem_req_write_o;
                    wait_cnt = 0;
                end else if (dmem_req_addr_o !== a0 || dmem_req_wdata_o !== w0 ||
                             dmem_req_mask_o !== m0 || dmem_req_write_o !== wr0) begin
                    stable_err++;
                end
                last_addr  = dmem_req_addr_o;
                last_wdata = dmem_req_wdata_o;
                last_mask  = dmem_req_mask_o;
                last_write = dmem_req_write_o;
                if (wait_cnt < ready_delay) begin
                    dmem_req_ready_i = 1'b0;
                    wait_cnt++;
                end else begin
                    dmem_req_ready_i = 1'b1;
                end
            end else begin
                dmem_req_ready_i = 1'b0;
            end
            vld_prev = dmem_req_valid_o;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (result_valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(result_valid_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rf_wen", 32'(rf_wen_o), 32'(e.wen));
                    chk("rf_waddr", 32'(rf_waddr_o), 32'(e.waddr));
                    if (e.chk_data) chk("rf_wdata", rf_wdata_o, e.wdata);
                    chk("misalign", 32'(misalign_o), 32'(e.mis));
                end
            end else begin
                chk("wen_outside_done", 32'(rf_wen_o), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic go_idle(input int n);
        valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; is_byte_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Presents one instruction and holds it until the stage stops stalling.
    task automatic do_op(input bit ld, input bit st, input bit by, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd,
                         input logic [31:0] exp_data, input bit b2b, input bit exp_mis,
                         output int lat);
        exp_t e;
        valid_i = 1'b1; is_load_i = ld; is_store_i = st; is_byte_i = by;
        addr_i = a; store_data_i = d; rd_addr_i = rd;
        e.wen = ld & ~exp_mis; e.waddr = rd; e.wdata = exp_data;
        e.chk_data = ld & ~exp_mis; e.mis = exp_mis;
        sb.push_back(e);
        if (b2b) @(negedge clk);
        #1;
        chk("stall_accept", 32'(stall_o), 32'd1);
        lat = 1;
        forever begin
            @(negedge clk);
            #1;
            lat++;
            if (lat == 2) chk("req_issued", 32'(dmem_req_valid_o), 32'(!exp_mis));
            if (!stall_o) break;
            if (lat > 40) begin
                chk("op_timeout", 32'(lat), 32'd0);
                break;
            end
        end
        chk("done_pulse", 32'(result_valid_o), 32'd1);
    endtask

    initial begin : stimulus
        int lat;
        int n0;
        bit in_resp;
        reset = 1'b1;
        valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; is_byte_i = 1'b0;
        addr_i = '0; store_data_i = '0; rd_addr_i = '0;
        mem[30'h40] = 32'h1122_3344;   // 0x100
        mem[30'h10] = 32'hCAFE_F00D;   // 0x40
        mem[30'h01] = 32'h5566_7788;   // 0x4
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_result_valid", 32'(result_valid_o), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst_rf_wdata", rf_wdata_o, 32'd0);
        chk("rst_req_valid", 32'(dmem_req_valid_o), 32'd0);
        chk("rst_req_write", 32'(dmem_req_write_o), 32'd0);
        chk("rst_req_addr", dmem_req_addr_o, 32'd0);
        chk("rst_req_wdata", dmem_req_wdata_o, 32'd0);
        chk("rst_req_mask", 32'(dmem_req_mask_o), 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Non-memory instruction: no stall, no request
        valid_i = 1'b1;
        #1;
        chk("nonmem_stall", 32'(stall_o), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("nonmem_req", 32'(dmem_req_valid_o), 32'd0);
        go_idle(1);

        // SB 0x203
        do_op(1'b0, 1'b1, 1'b1, 32'h203, 32'h0000_00A5, 5'd0, 32'h0, 1'b0, 1'b0, lat);
        chk("sb_latency", 32'(lat), 32'd3);
        chk("sb_mask", 32'(last_mask), 32'h8);
        chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
        chk("sb_write", 32'(last_write), 32'd1);
        chk("sb_addr", last_addr, 32'h203);
        go_idle(2);

        // LBU 0x102 rd=9 -> lane 2 of 0x11223344
        do_op(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 5'd9, 32'h0000_0022, 1'b0, 1'b0, lat);
        chk("lbu_stall_cycles", 32'(lat - 1), 32'd3);
        chk("lbu_mask", 32'(last_mask), 32'h0);
        chk("lbu_write", 32'(last_write), 32'd0);
        go_idle(2);

        // LW 0x40 with ready held low for 5 cycles
        ready_delay = 5;
        n0 = n_req;
        do_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 5'd5, 32'hCAFE_F00D, 1'b0, 1'b0, lat);
        chk("lw_wait_latency", 32'(lat), 32'd9);
        chk("lw_req_stable", 32'(stable_err), 32'd0);
        chk("lw_single_req", 32'(n_req - n0), 32'd1);
        ready_delay = 0;
        go_idle(2);

        // SW 0x10 then LW 0x10 back to back
        do_op(1'b0, 1'b1, 1'b0, 32'h10, 32'h1234_5678, 5'd0, 32'h0, 1'b0, 1'b0, lat);
        chk("sw_latency", 32'(lat), 32'd3);
        chk("sw_mask", 32'(last_mask), 32'hF);
        chk("sw_wdata", last_wdata, 32'h1234_5678);
        do_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd7, 32'h1234_5678, 1'b1, 1'b0, lat);
        chk("b2b_lw_latency", 32'(lat), 32'd4);
        go_idle(2);

        // Misaligned word load
`ifdef CL_MEM_MISALIGN_CHK_EN
        n0 = n_req;
        do_op(1'b1, 1'b0, 1'b0, 32'h6, 32'h0, 5'd4, 32'h0, 1'b0, 1'b1, lat);
        chk("mis_latency", 32'(lat), 32'd2);
        chk("mis_no_req", 32'(n_req - n0), 32'd0);
`else
        do_op(1'b1, 1'b0, 1'b0, 32'h6, 32'h0, 5'd4, 32'h5566_7788, 1'b0, 1'b0, lat);
        chk("unal_latency", 32'(lat), 32'd4);
        chk("unal_addr", last_addr, 32'h6);
`endif
        go_idle(2);

        // Reset while waiting for the LW 0x100 response
        resp_block = 1;
        valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; is_byte_i = 1'b0;
        addr_i = 32'h100; rd_addr_i = 5'd12;
        in_resp = 0;
        for (int i = 0; i < 20 && !in_resp; i++) begin
            @(negedge clk);
            #1;
            if (!dmem_req_valid_o && stall_o) in_resp = 1;
        end
        chk("reach_resp", 32'(in_resp), 32'd1);
        reset = 1'b1;
        valid_i = 1'b0; is_load_i = 1'b0;
        @(negedge clk);
        #1;
        chk("rr_req_valid", 32'(dmem_req_valid_o), 32'd0);
        chk("rr_stall", 32'(stall_o), 32'd0);
        chk("rr_result_valid", 32'(result_valid_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        stray_resp = 1;
        @(negedge clk);
        #1;
        stray_resp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rr_no_writeback", 32'(result_valid_o), 32'd0);
            chk("rr_idle_stall", 32'(stall_o), 32'd0);
        end
        resp_block = 0;

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
